// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: six-state ring counter (T1-T6) plus HALT,
// producing the per-cycle control word for the bus-attached datapath.
module sap_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       low_lm,
  output logic       low_ce,
  output logic       low_li,
  output logic       low_ei,
  output logic       low_la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       low_lb,
  output logic       low_lo,
  output logic [5:0] t_state,
  output logic       halt
);

  typedef enum logic [2:0] {
    S_T1   = 3'd0,
    S_T2   = 3'd1,
    S_T3   = 3'd2,
    S_T4   = 3'd3,
    S_T5   = 3'd4,
    S_T6   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t state;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_T1;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_T1:    state_next = S_T2;
      S_T2:    state_next = S_T3;
      S_T3:    state_next = S_T4;
      S_T4:    state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
      S_T5:    state_next = S_T6;
      S_T6:    state_next = S_T1;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_T1;
    endcase
  end

  // Reset forces the idle word even though the state register already reads T1,
  // so a reset landing mid-instruction never fires a load.
  always_comb begin
    cp     = 1'b0;
    ep     = 1'b0;
    low_lm = 1'b1;
    low_ce = 1'b1;
    low_li = 1'b1;
    low_ei = 1'b1;
    low_la = 1'b1;
    ea     = 1'b0;
    su     = 1'b0;
    eu     = 1'b0;
    low_lb = 1'b1;
    low_lo = 1'b1;
    if (!reset) begin
      case (state)
        S_T1: begin
          ep     = 1'b1;
          low_lm = 1'b0;
        end
        S_T2: begin
          cp = 1'b1;
        end
        S_T3: begin
          low_ce = 1'b0;
          low_li = 1'b0;
        end
        S_T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            low_ei = 1'b0;
            low_lm = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea     = 1'b1;
            low_lo = 1'b0;
          end
        end
        S_T5: begin
          if (opcode == OP_LDA) begin
            low_ce = 1'b0;
            low_la = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            low_ce = 1'b0;
            low_lb = 1'b0;
            su     = (opcode == OP_SUB);
          end
        end
        S_T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu     = 1'b1;
            low_la = 1'b0;
            su     = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    t_state = '0;
    halt    = 1'b0;
    case (state)
      S_T1:    t_state = 6'b000001;
      S_T2:    t_state = 6'b000010;
      S_T3:    t_state = 6'b000100;
      S_T4:    t_state = 6'b001000;
      S_T5:    t_state = 6'b010000;
      S_T6:    t_state = 6'b100000;
      S_HALT:  halt    = 1'b1;
      default: t_state = '0;
    endcase
  end

endmodule

// File: doc/sap_controller.md
# sap_controller

Controller-sequencer for the SAP-1 datapath. Generates the per-cycle control word that drives the bus-attached 8-bit tristate registers, program counter, MAR, RAM, ALU and output register. It issues the load enables and output enables those registers sample. A one-hot six-state ring counter (T1–T6) steps through fetch (T1–T3) and execute (T4–T6), decoding the instruction register's opcode nibble. It halts on HLT until reset.

## Interface
Parameters:
- OP_LDA, 4'h0, load-accumulator opcode
- OP_ADD, 4'h1, add opcode
- OP_SUB, 4'h2, subtract opcode
- OP_OUT, 4'hE, output opcode
- OP_HLT, 4'hF, halt opcode

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high reset
- opcode  in  4  IR[7:4]; stable T4–T6
- cp  out  1  PC increment (active high)
- ep  out  1  PC drive bus (active high)
- low_lm  out  1  MAR load (active low)
- low_ce  out  1  RAM drive bus (active low)
- low_li  out  1  IR load (active low)
- low_ei  out  1  IR address field drive bus (active low)
- low_la  out  1  A load (active low)
- ea  out  1  A drive bus (active high)
- su  out  1  ALU subtract select (active high)
- eu  out  1  ALU drive bus (active high)
- low_lb  out  1  B load (active low)
- low_lo  out  1  output register load (active low)
- t_state  out  6  one-hot ring state, bit0 = T1
- halt  out  1  high in HALT state

## Operation
- States: T1..T6 (one-hot ring), HALT. The next state after T6 is T1.
- Control outputs are combinational from the current state and opcode. Loads take effect at the posedge that ends the state.
- Idle word: cp=ep=ea=su=eu=0, all low_* = 1. This word is driven in HALT, in any unlisted state/opcode combination, and whenever reset=1.
- T1: ep=1, low_lm=0.
- T2: cp=1.
- T3: low_ce=0, low_li=0.
- LDA: T4 low_ei=0, low_lm=0; T5 low_ce=0, low_la=0; T6 idle.
- ADD: T4 low_ei=0, low_lm=0; T5 low_ce=0, low_lb=0; T6 eu=1, low_la=0.
- SUB: same as ADD, plus su=1 in both T5 and T6.
- OUT: T4 ea=1, low_lo=0; T5 and T6 idle.
- HLT: T4 idle. The next state is HALT instead of T5.
- Any other opcode is a NOP: T4–T6 idle, then T1.
- HALT: t_state=6'b000000, halt=1. The block stays in HALT until reset.
- Invariant: at most one bus driver (ep, ~low_ce, ~low_ei, ea, eu) is active in any cycle.

## Timing
- Reset values: the control word is the idle word, t_state=6'b000001 (T1) and halt=0 from the first posedge with reset=1.
- During the reset=1 cycles, the idle word is forced even though the state register reads T1.
- The T1 control word appears in the first cycle after reset deasserts.
- Instruction period is 6 cycles, fixed for every opcode except HLT.
- HLT reaches HALT at the posedge ending T4, 4 cycles after its T1.
- Reset mid-instruction: the cycle with reset=1 drives the idle word, so no load fires. The next cycle is T1.
- Opcode is sampled only in T4–T6; changes in T1–T3 have no effect.

## Test plan
- Reset for 2 cycles, then release:
  - During reset: idle word and t_state=000001.
  - First cycle after release: ep=1, low_lm=0.
  - Next cycle: cp=1 (T2).
- opcode=4'h0 (LDA), T1–T6:
  - T4: low_ei=0, low_lm=0.
  - T5: low_ce=0, low_la=0.
  - T6: idle.
  - The following cycle is T1 again.
- opcode=4'h2 (SUB):
  - T5: low_ce=0, low_lb=0, su=1.
  - T6: eu=1, low_la=0, su=1.
  - The same run with opcode=4'h1 gives su=0 throughout.
- opcode=4'hF (HLT):
  - After T4: halt=1, t_state=000000, idle word, held for 20 cycles.
  - Assert reset for 1 cycle: the block returns to T1.
- ADD with reset asserted in T5: low_lb stays 1 in that cycle, and the next cycle is T1.
- opcode=4'h5 (undefined): T4–T6 idle, then T1.
- Random opcodes over 1000 cycles: bus-driver exclusivity holds every cycle, and t_state is always one-hot or zero (zero only in HALT).
